// File: rtl/frame_seq_ctrl_if.sv
// Sample-input and FFT-sink handshake bundle for the frame sequencer.
// The slave side (the sequencer) takes audio samples plus FFT back-pressure
// and drives the framed FFT input stream. The master side is the surrounding
// logic: audio source, FFT core and testbench.
interface frame_seq_ctrl_if;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        fft_sink_ready;
  logic        fft_sink_valid;
  logic        fft_sink_sop;
  logic        fft_sink_eop;
  logic [15:0] fft_sink_real;

  modport slave (
    input  sample_valid,
    input  sample_in,
    input  fft_sink_ready,
    output fft_sink_valid,
    output fft_sink_sop,
    output fft_sink_eop,
    output fft_sink_real
  );

  modport master (
    output sample_valid,
    output sample_in,
    output fft_sink_ready,
    input  fft_sink_valid,
    input  fft_sink_sop,
    input  fft_sink_eop,
    input  fft_sink_real
  );
endinterface

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer for an FFT -> spectrum shift -> IFFT pipeline.
// Flow per frame: collect FRAME samples into the FFT, wait for the FFT to
// finish, open the shifter window for FRAME + 2*distance cycles, wait for the
// IFFT to finish, then pulse frame_done. Both wait states are guarded by a
// watchdog. Every output comes straight from a flop.
module frame_seq_ctrl #(
  parameter int FRAME = 512,
  parameter int TMO   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_seq_ctrl_if.slave      bus,
  input  logic                 i_enable,
  input  logic [6:0]           i_shift_dis,
  input  logic                 i_fft_source_eop,
  input  logic                 i_ifft_source_eop,
  output logic                 o_fc_enable,
  output logic [6:0]           o_dis_latched,
  output logic                 o_frame_done,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_timeout_err
);

  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_FFT  = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_IFFT = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_tmo_hit;

  logic [CW-1:0]  r_cnt;
  logic [WW-1:0]  r_wd;
  logic [10:0]    r_sh;
  logic [6:0]     r_dis;

  logic           r_sink_valid;
  logic           r_sink_sop;
  logic           r_sink_eop;
  logic [15:0]    r_sink_real;
  logic           r_fc;
  logic           r_done;
  logic           r_busy;
  logic           r_ovf;
  logic           r_tmo;

  logic           w_xfer;
  logic           w_drop;
  logic           w_last;
  logic           w_wd_end;
  logic [10:0]    w_win;
  logic           w_sh_last;

  // Sample acceptance, frame position and window/watchdog end conditions
  always_comb begin
    w_xfer    = (r_state == ST_FILL) && bus.sample_valid && bus.fft_sink_ready;
    w_drop    = (r_state == ST_FILL) && bus.sample_valid && !bus.fft_sink_ready;
    w_last    = (r_cnt == CW'(FRAME - 1));
    w_wd_end  = (r_wd == WW'(TMO - 1));
    // Window is FRAME + 2*distance; 11 bits covers the 766-cycle maximum.
    w_win     = 11'(FRAME) + {3'b000, r_dis, 1'b0};
    w_sh_last = (r_sh == (w_win - 11'd1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a watchdog expiry aborts straight back to IDLE
  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_next = ST_FILL;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_xfer && w_last) begin
          w_next = ST_WAIT_FFT;
        end else begin
          w_next = ST_FILL;
        end
      end
      ST_WAIT_FFT: begin
        if (i_fft_source_eop) begin
          w_next = ST_SHIFT;
        end else if (w_wd_end) begin
          w_next    = ST_IDLE;
          w_tmo_hit = 1'b1;
        end else begin
          w_next = ST_WAIT_FFT;
        end
      end
      ST_SHIFT: begin
        if (w_sh_last) begin
          w_next = ST_WAIT_IFFT;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_WAIT_IFFT: begin
        if (i_ifft_source_eop) begin
          w_next = ST_DONE;
        end else if (w_wd_end) begin
          w_next    = ST_IDLE;
          w_tmo_hit = 1'b1;
        end else begin
          w_next = ST_WAIT_IFFT;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: FFT sink stream, counters, latched distance, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_wd         <= '0;
      r_sh         <= 11'd0;
      r_dis        <= 7'd0;
      r_sink_valid <= 1'b0;
      r_sink_sop   <= 1'b0;
      r_sink_eop   <= 1'b0;
      r_sink_real  <= 16'd0;
      r_fc         <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_ovf        <= 1'b0;
      r_tmo        <= 1'b0;
    end else begin
      r_sink_valid <= w_xfer;
      r_sink_sop   <= w_xfer && (r_cnt == CW'(0));
      r_sink_eop   <= w_xfer && w_last;
      if (w_xfer) begin
        r_sink_real <= bus.sample_in;
      end

      // Distance is captured only on the frame start edge.
      if ((r_state == ST_IDLE) && i_enable) begin
        r_dis <= i_shift_dis;
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Watchdog restarts on any state change and runs only while waiting.
      if (w_next != r_state) begin
        r_wd <= '0;
      end else if ((r_state == ST_WAIT_FFT) || (r_state == ST_WAIT_IFFT)) begin
        r_wd <= r_wd + WW'(1);
      end

      if ((w_next == ST_SHIFT) && (r_state != ST_SHIFT)) begin
        r_sh <= 11'd0;
      end else if (r_state == ST_SHIFT) begin
        r_sh <= r_sh + 11'd1;
      end

      // State-aligned outputs are taken from the next state so they
      // change on the same edge as the state register.
      r_fc   <= (w_next == ST_SHIFT);
      r_done <= (w_next == ST_DONE);
      r_busy <= (w_next != ST_IDLE);

      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_tmo_hit) begin
        r_tmo <= 1'b1;
      end
    end
  end

  assign bus.fft_sink_valid = r_sink_valid;
  assign bus.fft_sink_sop   = r_sink_sop;
  assign bus.fft_sink_eop   = r_sink_eop;
  assign bus.fft_sink_real  = r_sink_real;
  assign o_fc_enable        = r_fc;
  assign o_dis_latched      = r_dis;
  assign o_frame_done       = r_done;
  assign o_busy             = r_busy;
  assign o_overflow         = r_ovf;
  assign o_timeout_err      = r_tmo;

endmodule
